// File: rtl/booth_pkg.sv
// Shared types and constants for the sequential Booth multiplier.
package booth_pkg;

    localparam int WIDTH_DEF = 8;
    localparam int CNT_W     = $clog2(WIDTH_DEF);

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_t;

endpackage

// File: rtl/booth_addsub.sv
// W-bit add/subtract, S = X + Y or S = X - Y.
// Y is XOR-inverted when SUB is set, and SUB is also used as the carry-in.
module booth_addsub #(
    parameter int W = 9
) (
    input  logic [W-1:0] X,
    input  logic [W-1:0] Y,
    input  logic         SUB,
    output logic [W-1:0] S
);

    logic [W-1:0] y_x;

    assign y_x = Y ^ {W{SUB}};
    assign S   = X + y_x + {{(W-1){1'b0}}, SUB};

endmodule

// File: rtl/booth_seq_mult.sv
// Radix-2 Booth multiplier that performs one iteration per clock.
// P and DONE are registered, so no input reaches an output combinationally.
//
// state | meaning
// IDLE  | waiting for START; P holds the last product
// RUN   | one Booth add/shift per edge, WIDTH edges in total
module booth_seq_mult
    import booth_pkg::*;
#(
    parameter int WIDTH = WIDTH_DEF
) (
    input  logic               CLK,
    input  logic               RST,
    input  logic               START,
    input  logic [WIDTH-1:0]   A,
    input  logic [WIDTH-1:0]   B,
    output logic [2*WIDTH-1:0] P,
    output logic               BUSY,
    output logic               DONE
);

    localparam int CW = (WIDTH == WIDTH_DEF) ? CNT_W : ((WIDTH > 1) ? $clog2(WIDTH) : 1);

    state_t            state, state_nxt;
    logic [WIDTH:0]    m, acc, sum, t, acc_sh;
    logic [WIDTH-1:0]  q, q_sh;
    logic              q_1;
    logic [CW-1:0]     count;
    logic              sub, use_sum, last;

    booth_addsub #(.W(WIDTH + 1)) u_addsub (
        .X   (acc),
        .Y   (m),
        .SUB (sub),
        .S   (sum)
    );

    // {q[0], q_1} = 10 subtracts M, 01 adds M, and 00 or 11 passes ACC through.
    always_comb begin
        sub     = q[0] & ~q_1;
        use_sum = q[0] ^ q_1;
        t       = use_sum ? sum : acc;
        acc_sh  = {t[WIDTH], t[WIDTH:1]};
        q_sh    = {t[0], q[WIDTH-1:1]};
        last    = (count == CW'(WIDTH - 1));
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (START) state_nxt = RUN;
            RUN:     if (last)  state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            m     <= '0;
            acc   <= '0;
            q     <= '0;
            q_1   <= 1'b0;
            count <= '0;
            P     <= '0;
            DONE  <= 1'b0;
        end else begin
            DONE <= 1'b0;
            case (state)
                IDLE: begin
                    if (START) begin
                        m     <= {A[WIDTH-1], A};
                        q     <= B;
                        acc   <= '0;
                        q_1   <= 1'b0;
                        count <= '0;
                    end
                end
                RUN: begin
                    acc   <= acc_sh;
                    q     <= q_sh;
                    q_1   <= q[0];
                    count <= count + 1'b1;
                    if (last) begin
                        P    <= {acc_sh[WIDTH-1:0], q_sh};
                        DONE <= 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    assign BUSY = (state == RUN);

endmodule

// File: tb/tb_booth_seq_mult.sv
// Directed bench for booth_seq_mult. A cycle-level product model is checked on every cycle,
// and hand-computed literal products pin down that model.
module tb_booth_seq_mult;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic [7:0]  a, b;
    logic [15:0] p;
    logic        busy, done;

    int checks   = 0;
    int failures = 0;

    booth_seq_mult #(.WIDTH(8)) dut (
        .CLK   (clk),
        .RST   (rst),
        .START (start),
        .A     (a),
        .B     (b),
        .P     (p),
        .BUSY  (busy),
        .DONE  (done)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%04h expected 0x%04h at %0t", name, act, exp, $time);
        end
    endtask

    // Model: an accepted request completes WIDTH edges later with the full signed product.
    int          rem;
    logic [15:0] m_prod, exp_p;
    logic        exp_done;

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            rem      = 0;
            exp_p    = '0;
            exp_done = 1'b0;
        end else begin
            exp_done = 1'b0;
            if (rem > 0) begin
                rem--;
                if (rem == 0) begin
                    exp_p    = m_prod;
                    exp_done = 1'b1;
                end
            end else if (start) begin
                rem    = 8;
                m_prod = 16'(int'($signed(a)) * int'($signed(b)));
            end
        end
    end

    always @(negedge clk) begin
        check("cyc_busy", {15'd0, busy}, {15'd0, rem > 0});
        check("cyc_done", {15'd0, done}, {15'd0, exp_done});
        check("cyc_p", p, exp_p);
    end

    // One START pulse, then wait for DONE and check its timing and the literal product.
    task automatic run_op(input logic [7:0] ai, input logic [7:0] bi, input logic [15:0] lit,
                          input string name);
        int cyc   = 0;
        int nbusy = 0;
        bit seen  = 0;
        @(negedge clk);
        #1;
        a = ai; b = bi; start = 1'b1;
        while (!seen && cyc < 20) begin
            @(negedge clk);
            cyc++;
            #1;
            if (cyc == 1) start = 1'b0;
            if (busy) nbusy++;
            if (done) seen = 1;
        end
        check({name, "_seen"}, {15'd0, seen}, 16'd1);
        check({name, "_lat"}, 16'(cyc), 16'd9);
        check({name, "_busycyc"}, 16'(nbusy), 16'd8);
        check({name, "_p"}, p, lit);
    endtask

    initial begin
        int ndone;
        int dpos [3];
        rst = 1'b1; start = 1'b0; a = '0; b = '0;
        repeat (2) @(negedge clk);
        #1;
        check("rst_p", p, 16'h0000);
        check("rst_busy", {15'd0, busy}, 16'd0);
        rst = 1'b0;

        run_op(8'd3,   8'd5,   16'h000F, "3x5");
        run_op(8'h80,  8'h80,  16'h4000, "m128xm128");
        run_op(8'd127, 8'h80,  16'hC080, "127xm128");
        run_op(8'hFF,  8'd1,   16'hFFFF, "m1x1");
        run_op(8'd0,   8'hB3,  16'h0000, "0xm77");

        // Re-pulsing START during RUN cycles 2 and 5 with other operands is ignored.
        @(negedge clk);
        #1;
        a = 8'hFB; b = 8'd9; start = 1'b1;
        ndone = 0;
        for (int i = 1; i <= 20; i++) begin
            @(negedge clk);
            #1;
            start = 1'b0;
            if (i == 1 || i == 4) begin a = 8'd100; b = 8'd100; start = 1'b1; end
            if (i == 2 || i == 5) begin a = 8'd7; b = 8'd7; end
            if (done) begin
                ndone++;
                check("ignore_p", p, 16'hFFD3);
            end
        end
        check("ignore_ndone", 16'(ndone), 16'd1);

        // Holding START high restarts in every DONE cycle.
        @(negedge clk);
        #1;
        a = 8'd2; b = 8'd3; start = 1'b1;
        ndone = 0;
        for (int i = 1; i <= 27; i++) begin
            @(negedge clk);
            #1;
            if (done) begin
                if (ndone < 3) dpos[ndone] = i;
                ndone++;
                check("hold_p", p, 16'h0006);
            end
        end
        start = 1'b0;
        check("hold_ndone", 16'(ndone), 16'd3);
        check("hold_pos0", 16'(dpos[0]), 16'd9);
        check("hold_pos2", 16'(dpos[2]), 16'd27);
        repeat (12) @(negedge clk);

        // Reset asserted mid-cycle during RUN aborts the operation without a DONE.
        @(negedge clk);
        #1;
        a = 8'd10; b = 8'd10; start = 1'b1;
        @(negedge clk);
        #1;
        start = 1'b0;
        repeat (3) @(negedge clk);
        @(posedge clk);
        #2;
        rst = 1'b1;
        #1;
        check("arst_busy", {15'd0, busy}, 16'd0);
        check("arst_done", {15'd0, done}, 16'd0);
        check("arst_p", p, 16'h0000);
        repeat (2) @(negedge clk);
        #1;
        rst = 1'b0;
        ndone = 0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (done) ndone++;
        end
        check("arst_nodone", 16'(ndone), 16'd0);
        run_op(8'hF9, 8'd6, 16'hFFD6, "m7x6");

        repeat (3) @(negedge clk);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
